// File: rtl/seven_segment_scanner.sv
// Multiplexed seven-segment scanner with blank window, PWM dimming and frame-synchronous capture.
// Define SEVSEG_LZB_EN to enable leading-zero blanking.
module seven_segment_scanner #(
  parameter int NUM_DIGITS   = 8,
  parameter int SLOT_CYCLES  = 12500,
  parameter int BLANK_CYCLES = 64,
  parameter int BRIGHT_W     = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [4*NUM_DIGITS-1:0]       value,
  input  logic [NUM_DIGITS-1:0]         dp_mask,
  input  logic [NUM_DIGITS-1:0]         digit_en,
  input  logic [BRIGHT_W-1:0]           brightness,
  output logic [NUM_DIGITS-1:0]         an,
  output logic [6:0]                    seg,
  output logic                          dp,
  output logic                          frame_start,
  output logic [$clog2(NUM_DIGITS)-1:0] cur_digit
);
  localparam int DIG_W  = $clog2(NUM_DIGITS);
  localparam int SLOT_W = $clog2(SLOT_CYCLES);
  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_ON    = 1'b1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_CYCLES - 1);
  localparam logic [SLOT_W-1:0] BLANK_END = SLOT_W'(BLANK_CYCLES);
  localparam logic [DIG_W-1:0]  DIG_LAST  = DIG_W'(NUM_DIGITS - 1);

  logic [SLOT_W-1:0]       slot_cnt_q, slot_cnt_d;
  logic [DIG_W-1:0]        cur_digit_q, cur_digit_d;
  logic [0:0]              state_q, state_d;
  logic [BRIGHT_W-1:0]     pwm_cnt_q, pwm_cnt_d;
  logic [4*NUM_DIGITS-1:0] value_sh_q, value_sh_d;
  logic [NUM_DIGITS-1:0]   dp_sh_q, dp_sh_d;
  logic [NUM_DIGITS-1:0]   en_sh_q, en_sh_d;
  logic [BRIGHT_W-1:0]     bright_sh_q, bright_sh_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic                    slot_wrap;
  logic                    is_blank;
  logic                    lit;
  logic [3:0]              nibble;
  logic [6:0]              font;

  // Gated by reset so the pulse (and shadow capture) only occurs once the scan runs.
  assign frame_start = ~reset & (slot_cnt_q == '0) & (cur_digit_q == '0);
  assign cur_digit   = cur_digit_q;
  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = dp_q;

`ifdef SEVSEG_LZB_EN
  logic [NUM_DIGITS-1:0] blank_q, blank_d;
  logic                  zero_run;

  // A digit blanks only when it and every digit to its left are zero with no dp.
  always_comb begin
    blank_d  = blank_q;
    zero_run = 1'b1;
    if (frame_start) begin
      blank_d = '0;
      for (int unsigned i = NUM_DIGITS - 1; i >= 1; i--) begin
        zero_run   = zero_run & (value[4*i +: 4] == 4'h0) & ~dp_mask[i];
        blank_d[i] = zero_run;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) blank_q <= '0;
    else       blank_q <= blank_d;
  end

  assign is_blank = blank_q[cur_digit_q];
`else
  assign is_blank = 1'b0;
`endif

  always_comb begin
    slot_wrap   = (slot_cnt_q == SLOT_LAST);
    slot_cnt_d  = slot_wrap ? '0 : slot_cnt_q + 1'b1;
    cur_digit_d = cur_digit_q;
    if (slot_wrap) cur_digit_d = (cur_digit_q == DIG_LAST) ? '0 : cur_digit_q + 1'b1;

    state_d = state_q;
    case (state_q)
      ST_BLANK: if (slot_cnt_d == BLANK_END) state_d = ST_ON;
      default:  if (slot_wrap) state_d = ST_BLANK;
    endcase
    pwm_cnt_d = (state_q == ST_ON) ? pwm_cnt_q + 1'b1 : '0;

    value_sh_d  = frame_start ? value      : value_sh_q;
    dp_sh_d     = frame_start ? dp_mask    : dp_sh_q;
    en_sh_d     = frame_start ? digit_en   : en_sh_q;
    bright_sh_d = frame_start ? brightness : bright_sh_q;
  end

  always_comb begin
    nibble = value_sh_q[{cur_digit_q, 2'b00} +: 4];
    case (nibble)
      4'h0: font = 7'b0111111;
      4'h1: font = 7'b0000110;
      4'h2: font = 7'b1011011;
      4'h3: font = 7'b1001111;
      4'h4: font = 7'b1100110;
      4'h5: font = 7'b1101101;
      4'h6: font = 7'b1111101;
      4'h7: font = 7'b0000111;
      4'h8: font = 7'b1111111;
      4'h9: font = 7'b1101111;
      4'hA: font = 7'b1110111;
      4'hB: font = 7'b1111100;
      4'hC: font = 7'b0111001;
      4'hD: font = 7'b1011110;
      4'hE: font = 7'b1111001;
      default: font = 7'b1110001;
    endcase
    lit = (state_q == ST_ON) && en_sh_q[cur_digit_q] && !is_blank &&
          ((&bright_sh_q) || (pwm_cnt_q < bright_sh_q));
    an_d  = lit ? ~(NUM_DIGITS'(1) << cur_digit_q) : '1;
    seg_d = lit ? font : '0;
    dp_d  = lit & dp_sh_q[cur_digit_q];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_cnt_q  <= '0;
      cur_digit_q <= '0;
      state_q     <= ST_BLANK;
      pwm_cnt_q   <= '0;
      value_sh_q  <= '0;
      dp_sh_q     <= '0;
      en_sh_q     <= '0;
      bright_sh_q <= '0;
      an_q        <= '1;
      seg_q       <= '0;
      dp_q        <= 1'b0;
    end else begin
      slot_cnt_q  <= slot_cnt_d;
      cur_digit_q <= cur_digit_d;
      state_q     <= state_d;
      pwm_cnt_q   <= pwm_cnt_d;
      value_sh_q  <= value_sh_d;
      dp_sh_q     <= dp_sh_d;
      en_sh_q     <= en_sh_d;
      bright_sh_q <= bright_sh_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end
endmodule

// File: tb/tb_seven_segment_scanner.sv
// Bench for seven_segment_scanner: per-frame vector table plus hand sequences for scan timing,
// PWM pattern, tear-free capture and mid-frame reset. LZB expectations follow SEVSEG_LZB_EN.
module tb_seven_segment_scanner;
  logic        clk;
  logic        reset;
  logic [15:0] value;
  logic [3:0]  dp_mask;
  logic [3:0]  digit_en;
  logic [1:0]  brightness;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;
  logic [1:0]  cur_digit;

  int n_checks;
  int n_errors;
  int cyc;

`ifdef SEVSEG_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  seven_segment_scanner #(
    .NUM_DIGITS(4), .SLOT_CYCLES(40), .BLANK_CYCLES(4), .BRIGHT_W(2)
  ) dut (
    .clk(clk), .reset(reset), .value(value), .dp_mask(dp_mask), .digit_en(digit_en),
    .brightness(brightness), .an(an), .seg(seg), .dp(dp), .frame_start(frame_start),
    .cur_digit(cur_digit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] value;
    logic [3:0]  dp_mask;
    logic [3:0]  digit_en;
    logic [1:0]  bright;
    logic [31:0] cnt;   // expected lit cycles per digit, 8 bits each
    logic [27:0] segs;  // expected segment code per digit, 7 bits each
  } vec_t;

  function automatic vec_t mk(logic [15:0] v, logic [3:0] d, logic [3:0] e, logic [1:0] b,
                              int c3, int c2, int c1, int c0,
                              logic [6:0] s3, logic [6:0] s2, logic [6:0] s1, logic [6:0] s0);
    vec_t r;
    r.value = v; r.dp_mask = d; r.digit_en = e; r.bright = b;
    r.cnt  = {8'(c3), 8'(c2), 8'(c1), 8'(c0)};
    r.segs = {s3, s2, s1, s0};
    return r;
  endfunction

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("reset_an", an, 4'hF);
    check("reset_seg", seg, 0);
    check("reset_dp", dp, 0);
    check("reset_frame_start", frame_start, 0);
    check("reset_cur_digit", cur_digit, 0);
    reset = 1'b0;
    #1;
    cyc = 0;
    check("release_frame_start", frame_start, 1);
    check("release_cur_digit", cur_digit, 0);
  endtask

  task automatic apply(logic [15:0] v, logic [3:0] d, logic [3:0] e, logic [1:0] b);
    value = v; dp_mask = d; digit_en = e; brightness = b;
  endtask

  vec_t vecs[8];

  initial begin
    int cnt[4];
    int fs_extra;
    int dig;
    int c2, c3, seen71;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;

    n_checks = 0; n_errors = 0; cyc = 0;
    reset = 1'b1;
    apply(16'h0000, 4'h0, 4'h0, 2'd0);

    vecs[0] = mk(16'h1234, 4'h0, 4'hF, 2'd3, 36, 36, 36, 36, 7'h06, 7'h5B, 7'h4F, 7'h66);
    vecs[1] = mk(16'h1234, 4'h0, 4'hF, 2'd1,  9,  9,  9,  9, 7'h06, 7'h5B, 7'h4F, 7'h66);
    vecs[2] = mk(16'h1234, 4'h0, 4'hF, 2'd0,  0,  0,  0,  0, 7'h06, 7'h5B, 7'h4F, 7'h66);
    vecs[3] = mk(16'h8A0F, 4'b0101, 4'b1011, 2'd3, 36, 0, 36, 36, 7'h7F, 7'h77, 7'h3F, 7'h71);
    vecs[4] = mk(16'h0050, 4'h0, 4'hF, 2'd3, LZB ? 0 : 36, LZB ? 0 : 36, 36, 36,
                 7'h3F, 7'h3F, 7'h6D, 7'h3F);
    vecs[5] = mk(16'h0000, 4'h0, 4'hF, 2'd3, LZB ? 0 : 36, LZB ? 0 : 36, LZB ? 0 : 36, 36,
                 7'h3F, 7'h3F, 7'h3F, 7'h3F);
    vecs[6] = mk(16'h0005, 4'b1000, 4'hF, 2'd3, 36, 36, 36, 36, 7'h3F, 7'h3F, 7'h3F, 7'h6D);
    vecs[7] = mk(16'hC0DE, 4'h0, 4'hF, 2'd2, 18, 18, 18, 18, 7'h39, 7'h3F, 7'h5E, 7'h79);

    // One full frame per vector: count lit cycles per digit and check each lit code.
    for (int unsigned k = 0; k < 8; k++) begin
      apply(vecs[k].value, vecs[k].dp_mask, vecs[k].digit_en, vecs[k].bright);
      do_reset();
      for (int i = 0; i < 4; i++) cnt[i] = 0;
      fs_extra = 0;
      for (int c = 1; c <= 160; c++) begin
        next_cycle();
        if (c < 160 && frame_start) fs_extra++;
        if (an != 4'hF) begin
          check("an_single_low", $countones(~an), 1);
          dig = 0;
          for (int i = 0; i < 4; i++) if (!an[i]) dig = i;
          cnt[dig]++;
          check("vec_seg", seg, vecs[k].segs[7*dig +: 7]);
          check("vec_dp", dp, vecs[k].dp_mask[dig]);
        end else begin
          check("dark_seg", seg, 0);
        end
      end
      check("frame_start_period", frame_start, 1);
      check("frame_start_extra", fs_extra, 0);
      for (int i = 0; i < 4; i++) check("vec_lit_count", cnt[i], vecs[k].cnt[8*i +: 8]);
    end

    // Exact scan timing at full brightness.
    apply(16'h1234, 4'h0, 4'hF, 2'd3);
    do_reset();
    for (int c = 0; c <= 45; c++) begin
      if (c > 0) next_cycle();
      exp_an = 4'hF; exp_seg = 7'h00;
      if (c >= 5 && c <= 40) begin exp_an = 4'b1110; exp_seg = 7'b1100110; end
      if (c == 45)           begin exp_an = 4'b1101; exp_seg = 7'b1001111; end
      check("scan_an", an, exp_an);
      check("scan_seg", seg, exp_seg);
    end

    // PWM at brightness 1: one lit cycle in every four across the ON window.
    apply(16'h1234, 4'h0, 4'hF, 2'd1);
    do_reset();
    for (int c = 1; c <= 44; c++) begin
      next_cycle();
      exp_an = (c >= 5 && c <= 40 && ((c - 5) % 4) == 0) ? 4'b1110 : 4'hF;
      check("pwm_an", an, exp_an);
    end

    // Inputs changed during digit 2's slot must not reach the display until the next frame.
    apply(16'h1234, 4'h0, 4'hF, 2'd3);
    do_reset();
    while (cyc < 85) next_cycle();
    value = 16'hFFFF; brightness = 2'd1;
    c2 = 0; c3 = 0; seen71 = 0;
    for (int c = 85; c <= 160; c++) begin
      if (c > 85) next_cycle();
      if (an == 4'b1011) begin c2++; check("tear_d2_seg", seg, 7'h5B); end
      if (an == 4'b0111) begin c3++; check("tear_d3_seg", seg, 7'h06); end
      if (seg == 7'b1110001) seen71++;
    end
    check("tear_d2_count", c2, 36);
    check("tear_d3_count", c3, 36);
    check("tear_no_early_F", seen71, 0);
    while (cyc < 165) next_cycle();
    check("tear_new_an", an, 4'b1110);
    check("tear_new_seg", seg, 7'b1110001);
    next_cycle();
    check("tear_new_pwm_an", an, 4'hF);

    // Reset during digit 2's ON window.
    apply(16'h1234, 4'h0, 4'hF, 2'd3);
    do_reset();
    while (cyc < 100) next_cycle();
    check("mid_an_before", an, 4'b1011);
    check("mid_cur_digit_before", cur_digit, 2);
    reset = 1'b1;
    #1;
    check("mid_frame_start_in_reset", frame_start, 0);
    next_cycle();
    check("mid_an_after", an, 4'hF);
    check("mid_seg_after", seg, 0);
    check("mid_cur_digit_after", cur_digit, 0);
    reset = 1'b0;
    #1;
    cyc = 0;
    check("mid_release_frame_start", frame_start, 1);
    check("mid_release_cur_digit", cur_digit, 0);
    while (cyc < 5) next_cycle();
    check("mid_restart_an", an, 4'b1110);
    check("mid_restart_seg", seg, 7'b1100110);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/seven_segment_scanner.md
# seven_segment_scanner

Parametrised multiplexed seven-segment display controller running directly from the system clock, with no separate slow clock. It scans `NUM_DIGITS` hex digits and applies an anti-ghosting blank window between digits, PWM brightness control, per-digit enables and tear-free frame-synchronous input capture. It sits between the calculator datapath, which supplies `value`/`dp_mask`, and the board anode/segment pins.

## Interface
- `NUM_DIGITS`, 8: digits scanned, legal 2..16.
- `SLOT_CYCLES`, 12500: clk cycles per digit slot.
- `BLANK_CYCLES`, 64: blank cycles at slot start, ≥2.
- `BRIGHT_W`, 4: brightness width. Constraint: `SLOT_CYCLES` > `BLANK_CYCLES` + 2^`BRIGHT_W`.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `value`  in  4*NUM_DIGITS  nibble k drives digit k; digit NUM_DIGITS-1 is leftmost.
- `dp_mask`  in  NUM_DIGITS  1 = decimal point on.
- `digit_en`  in  NUM_DIGITS  1 = digit may light.
- `brightness`  in  BRIGHT_W  0 = dark, all-ones = full on.
- `an`  out  NUM_DIGITS  active-low anodes, at most one low.
- `seg`  out  7  active-high segments; bit0 = a … bit6 = g.
- `dp`  out  1  active-high decimal point.
- `frame_start`  out  1  one-cycle pulse in cycle 0 of digit 0's slot.
- `cur_digit`  out  clog2(NUM_DIGITS)  digit currently owning the slot.

## Operation
- **Counters**
  - `slot_cnt` counts 0..SLOT_CYCLES-1 and wraps.
  - At the wrap, `cur_digit` increments, wrapping from NUM_DIGITS-1 to 0.
- **State machine**, one pass per slot:
  - BLANK: `slot_cnt` < BLANK_CYCLES.
  - ON: remaining cycles of the slot.
  - BLANK→ON at `slot_cnt` == BLANK_CYCLES. ON→BLANK at the slot wrap.
- **Shadow capture**
  - `value`, `dp_mask`, `digit_en` and `brightness` are captured into shadow registers at the clock edge ending the `frame_start` cycle.
  - All display decisions use the shadows only, so input changes mid-frame never reach the display before the next frame.
- **PWM**
  - `pwm_cnt` is BRIGHT_W bits. It is cleared on entering ON and increments every ON cycle, wrapping.
  - The digit is lit when in ON, its shadow `digit_en` bit is 1, it is not LZB-blanked, and either `brightness` == all-ones or `pwm_cnt` < `brightness`.
- **Output when lit**
  - `an[cur_digit]`=0, all other anodes 1.
  - `seg` = hex decode of the nibble: 0→0111111, 1→0000110, 4→1100110, 8→1111111, A→1110111, F→1110001, standard 0-F font.
  - `dp` = shadow `dp_mask[cur_digit]`.
- **Output when not lit**: `an` all ones, `seg`=0, `dp`=0.
- A disabled or blanked digit still consumes its full slot, so the frame period is always NUM_DIGITS×SLOT_CYCLES.

## Timing
- `an`, `seg` and `dp` are registered, one cycle behind the state and counters.
- `frame_start` and `cur_digit` are aligned with the counters, not delayed.
- **Reset**, applied on the clock edge while `reset`=1:
  - `an` = all ones; `seg`=0; `dp`=0; `frame_start`=0; `cur_digit`=0.
  - `slot_cnt`=0, state BLANK, shadows cleared.
- **First cycle after reset release** is digit 0, `slot_cnt`=0; `frame_start`=1 in that cycle.
- **Reset mid-slot**: outputs go dark on the next edge and the scan restarts at digit 0.
- **Change of `brightness`** takes effect at the next frame only.
- **Minimum dark time**: the BLANK window guarantees at least BLANK_CYCLES dark cycles between any two different anodes going low.

## Configuration
- Macro `SEVSEG_LZB_EN` enables leading-zero blanking.
- **When defined**:
  - Digit k>0 is blanked iff every shadow nibble k..NUM_DIGITS-1 is 0 and no shadow `dp_mask` bit in k..NUM_DIGITS-1 is set.
  - Digit 0 is never blanked.
  - The blank mask is registered at shadow capture.
- **When undefined**: no blanking logic is present and all enabled digits display.

## Test plan
Bench parameters: NUM_DIGITS=4, SLOT_CYCLES=40, BLANK_CYCLES=4, BRIGHT_W=2.
- **Reset and scan**: `value`=16'h1234, `brightness`=3, `digit_en`=4'hF. Required response:
  - `frame_start` is high in the first cycle after release.
  - `an`=1111 for the first 5 cycles, then 1110 with `seg`=1100110 for 36 cycles.
  - Then 1111 for 4 cycles, then 1101 with `seg`=1001111.
- **PWM**:
  - `brightness`=1: `an[0]` is low exactly 9 of 36 ON cycles, in a 1-low-3-high pattern.
  - `brightness`=0: `an` never goes low.
- **Tear-free capture**: change `value` to 16'hFFFF during digit 2's slot → digits 2 and 3 still show 2 and 1. `seg`=1110001 appears only after the next `frame_start`.
- **Digit enable**: `digit_en`=4'b1011 → `an[2]` is never low, and `frame_start` period stays 160 cycles.
- **LZB, macro defined**:
  - `value`=16'h0050 → digits 3 and 2 dark; digit 1 shows 5, digit 0 shows 0.
  - `value`=0 → only digit 0 lit.
  - `value`=16'h0005 with `dp_mask`=4'b1000 → digit 3 lit with `dp`=1.
- **LZB, macro undefined**: `value`=16'h0050 → all four digits lit.
- **Reset mid-frame**: assert `reset` during digit 2's ON window → `an`=1111 on the next edge. After release, `cur_digit`=0 and `frame_start`=1.
